// File: rtl/sys_if_pkg.sv
// Shared types and constants for the AXI4-Lite to sys_if register bus bridge.
package sys_if_pkg;

    localparam int unsigned SYS_IF_AW = 32;
    localparam int unsigned SYS_IF_DW = 32;
    localparam int unsigned STRB_W    = SYS_IF_DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_PULSE = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_ADDR  = 3'd3,
        ST_RD_RESP  = 3'd4
    } bridge_state_e;

    typedef struct packed {
        logic [STRB_W-1:0]    strb;
        logic [SYS_IF_DW-1:0] data;
    } wr_beat_t;

endpackage

// File: rtl/axil_chan_hold.sv
// One-deep holding register for an AXI4-Lite request channel; ready drops while full.
module axil_chan_hold #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_init,
    input  logic         i_valid,
    output logic         o_ready_c,
    input  logic [W-1:0] i_data,
    input  logic         i_clr,
    output logic [W-1:0] o_data,
    output logic         o_held
);

    logic         r_held;
    logic [W-1:0] r_data;
    logic         w_capture;

    assign o_ready_c = i_init & ~r_held;
    assign w_capture = i_valid & o_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held <= 1'b0;
            r_data <= '0;
        end else if (w_capture) begin
            r_held <= 1'b1;
            r_data <= i_data;
        end else if (i_clr) begin
            r_held <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_held = r_held;

endmodule

// File: rtl/sys_if_axil_bridge.sv
// AXI4-Lite slave driving the single-cycle sys_if register bus.
// Reads and writes are serialised; simultaneous requests alternate round-robin.
module sys_if_axil_bridge
    import sys_if_pkg::*;
#(
    parameter logic [SYS_IF_AW-1:0] ADDR_SPAN = 32'h40
) (
    input  logic                 sys_if_clk,
    input  logic                 sys_if_rstn,
    input  logic [SYS_IF_AW-1:0] s_axil_awaddr,
    input  logic                 s_axil_awvalid,
    output logic                 s_axil_awready,
    input  logic [SYS_IF_DW-1:0] s_axil_wdata,
    input  logic [STRB_W-1:0]    s_axil_wstrb,
    input  logic                 s_axil_wvalid,
    output logic                 s_axil_wready,
    output logic [1:0]           s_axil_bresp,
    output logic                 s_axil_bvalid,
    input  logic                 s_axil_bready,
    input  logic [SYS_IF_AW-1:0] s_axil_araddr,
    input  logic                 s_axil_arvalid,
    output logic                 s_axil_arready,
    output logic [SYS_IF_DW-1:0] s_axil_rdata,
    output logic [1:0]           s_axil_rresp,
    output logic                 s_axil_rvalid,
    input  logic                 s_axil_rready,
    output logic                 sys_if_wen,
    output logic [SYS_IF_AW-1:0] sys_if_addr,
    output logic [SYS_IF_DW-1:0] sys_if_wdata,
    input  logic [SYS_IF_DW-1:0] sys_if_rdata
);

    localparam int unsigned BEAT_W = $bits(wr_beat_t);

    logic                 r_init;
    bridge_state_e        r_state;
    bridge_state_e        w_state_nxt;
    logic                 r_last_wr;
    logic                 r_wr_err;
    logic                 r_rd_err;
    logic                 r_wen;
    logic [SYS_IF_AW-1:0] r_addr;
    logic [SYS_IF_DW-1:0] r_wdata;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic                 r_rvalid;
    logic [1:0]           r_rresp;
    logic [SYS_IF_DW-1:0] r_rdata;

    logic                 w_last_wr_nxt;
    logic                 w_wr_err_nxt;
    logic                 w_rd_err_nxt;
    logic                 w_wen_nxt;
    logic [SYS_IF_AW-1:0] w_addr_nxt;
    logic [SYS_IF_DW-1:0] w_wdata_nxt;
    logic                 w_bvalid_nxt;
    logic [1:0]           w_bresp_nxt;
    logic                 w_rvalid_nxt;
    logic [1:0]           w_rresp_nxt;
    logic [SYS_IF_DW-1:0] w_rdata_nxt;

    logic [SYS_IF_AW-1:0] w_aw_addr;
    logic [SYS_IF_AW-1:0] w_ar_addr;
    wr_beat_t             w_w_in;
    wr_beat_t             w_w_beat;
    logic                 w_aw_held;
    logic                 w_w_held;
    logic                 w_ar_held;
    logic                 w_clr_wr;
    logic                 w_clr_rd;
    logic                 w_wr_pend;
    logic                 w_rd_pend;
    logic                 w_grant_wr;
    logic                 w_grant_rd;
    logic                 w_wr_err;

    assign w_w_in = '{strb: s_axil_wstrb, data: s_axil_wdata};

    axil_chan_hold #(.W(SYS_IF_AW)) u_aw_hold (
        .clk       (sys_if_clk),
        .rst_n     (sys_if_rstn),
        .i_init    (r_init),
        .i_valid   (s_axil_awvalid),
        .o_ready_c (s_axil_awready),
        .i_data    (s_axil_awaddr),
        .i_clr     (w_clr_wr),
        .o_data    (w_aw_addr),
        .o_held    (w_aw_held)
    );

    axil_chan_hold #(.W(BEAT_W)) u_w_hold (
        .clk       (sys_if_clk),
        .rst_n     (sys_if_rstn),
        .i_init    (r_init),
        .i_valid   (s_axil_wvalid),
        .o_ready_c (s_axil_wready),
        .i_data    (w_w_in),
        .i_clr     (w_clr_wr),
        .o_data    (w_w_beat),
        .o_held    (w_w_held)
    );

    axil_chan_hold #(.W(SYS_IF_AW)) u_ar_hold (
        .clk       (sys_if_clk),
        .rst_n     (sys_if_rstn),
        .i_init    (r_init),
        .i_valid   (s_axil_arvalid),
        .o_ready_c (s_axil_arready),
        .i_data    (s_axil_araddr),
        .i_clr     (w_clr_rd),
        .o_data    (w_ar_addr),
        .o_held    (w_ar_held)
    );

    // Round-robin: on contention the kind not granted last time wins.
    assign w_wr_pend  = w_aw_held & w_w_held;
    assign w_rd_pend  = w_ar_held;
    assign w_grant_wr = w_wr_pend & (~w_rd_pend | ~r_last_wr);
    assign w_grant_rd = w_rd_pend & (~w_wr_pend |  r_last_wr);
    assign w_wr_err   = (w_aw_addr >= ADDR_SPAN) | (w_w_beat.strb != {STRB_W{1'b1}});

    always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_wr) begin
                    w_state_nxt = ST_WR_PULSE;
                end else if (w_grant_rd) begin
                    w_state_nxt = ST_RD_ADDR;
                end
            end
            ST_WR_PULSE: w_state_nxt = ST_WR_RESP;
            ST_WR_RESP:  if (s_axil_bready) w_state_nxt = ST_IDLE;
            ST_RD_ADDR:  w_state_nxt = ST_RD_RESP;
            ST_RD_RESP:  if (s_axil_rready) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of every registered output, plus holding-register clears.
    always_comb begin
        w_last_wr_nxt = r_last_wr;
        w_wr_err_nxt  = r_wr_err;
        w_rd_err_nxt  = r_rd_err;
        w_wen_nxt     = 1'b0;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_rvalid_nxt  = r_rvalid;
        w_rresp_nxt   = r_rresp;
        w_rdata_nxt   = r_rdata;
        w_clr_wr      = 1'b0;
        w_clr_rd      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_wr) begin
                    w_last_wr_nxt = 1'b1;
                    w_wr_err_nxt  = w_wr_err;
                    w_wen_nxt     = ~w_wr_err;
                    w_addr_nxt    = {w_aw_addr[SYS_IF_AW-1:2], 2'b00};
                    w_wdata_nxt   = w_w_beat.data;
                end else if (w_grant_rd) begin
                    w_last_wr_nxt = 1'b0;
                    w_rd_err_nxt  = (w_ar_addr >= ADDR_SPAN);
                    w_addr_nxt    = {w_ar_addr[SYS_IF_AW-1:2], 2'b00};
                end
            end
            ST_WR_PULSE: begin
                w_clr_wr     = 1'b1;
                w_bvalid_nxt = 1'b1;
                w_bresp_nxt  = r_wr_err ? RESP_SLVERR : RESP_OKAY;
            end
            ST_WR_RESP: begin
                if (s_axil_bready) w_bvalid_nxt = 1'b0;
            end
            ST_RD_ADDR: begin
                w_clr_rd     = 1'b1;
                w_rvalid_nxt = 1'b1;
                w_rresp_nxt  = r_rd_err ? RESP_SLVERR : RESP_OKAY;
                w_rdata_nxt  = r_rd_err ? '0 : sys_if_rdata;
            end
            ST_RD_RESP: begin
                if (s_axil_rready) w_rvalid_nxt = 1'b0;
            end
            default: begin
                w_wen_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            r_init    <= 1'b0;
            r_last_wr <= 1'b0;
            r_wr_err  <= 1'b0;
            r_rd_err  <= 1'b0;
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_init    <= 1'b1;
            r_last_wr <= w_last_wr_nxt;
            r_wr_err  <= w_wr_err_nxt;
            r_rd_err  <= w_rd_err_nxt;
            r_wen     <= w_wen_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end

    assign sys_if_wen    = r_wen;
    assign sys_if_addr   = r_addr;
    assign sys_if_wdata  = r_wdata;
    assign s_axil_bvalid = r_bvalid;
    assign s_axil_bresp  = r_bresp;
    assign s_axil_rvalid = r_rvalid;
    assign s_axil_rresp  = r_rresp;
    assign s_axil_rdata  = r_rdata;

endmodule

// File: tb/tb_sys_if_axil_bridge.sv
// Directed bench for sys_if_axil_bridge with a 16-word register block model.
module tb_sys_if_axil_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        sys_if_wen;
    logic [31:0] sys_if_addr;
    logic [31:0] sys_if_wdata;
    logic [31:0] sys_if_rdata;

    logic [31:0] mem [16];
    int          wen_cnt = 0;
    int          errors  = 0;
    int          checks  = 0;

    always #5 clk = ~clk;

    sys_if_axil_bridge #(.ADDR_SPAN(32'h40)) dut (
        .sys_if_clk     (clk),
        .sys_if_rstn    (rstn),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .sys_if_wen     (sys_if_wen),
        .sys_if_addr    (sys_if_addr),
        .sys_if_wdata   (sys_if_wdata),
        .sys_if_rdata   (sys_if_rdata)
    );

    // Register block model: combinational read, write on the edge ending the strobe.
    assign sys_if_rdata = mem[sys_if_addr[5:2]];

    always @(posedge clk) begin
        if (sys_if_wen === 1'b1) begin
            wen_cnt++;
            if (sys_if_addr < 32'h40) mem[sys_if_addr[5:2]] <= sys_if_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic exp_err, input int stall);
        logic       aw_hs, w_hs;
        bit         aw_done, w_done;
        int         n0;
        logic [1:0] exp_resp;
        n0       = wen_cnt;
        exp_resp = exp_err ? 2'b10 : 2'b00;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            tick();
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        checks++;
        if (!(aw_done && w_done)) begin
            errors++;
            $display("FAIL wr_accept addr=%h: aw_done=%0b w_done=%0b required 1 1", a, aw_done, w_done);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        tick();
        checks++;
        if (sys_if_wen !== !exp_err || sys_if_addr !== {a[31:2], 2'b00} || sys_if_wdata !== d || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse addr=%h: wen=%b addr=%h wdata=%h bvalid=%b required %b %h %h 0",
                     a, sys_if_wen, sys_if_addr, sys_if_wdata, bvalid, !exp_err, {a[31:2], 2'b00}, d);
        end
        tick();
        checks++;
        if (sys_if_wen !== 1'b0 || bvalid !== 1'b1 || bresp !== exp_resp) begin
            errors++;
            $display("FAIL wr_resp addr=%h: wen=%b bvalid=%b bresp=%b required 0 1 %b",
                     a, sys_if_wen, bvalid, bresp, exp_resp);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            checks++;
            if (bvalid !== 1'b1 || bresp !== exp_resp || sys_if_wen !== 1'b0) begin
                errors++;
                $display("FAIL wr_stall cycle %0d: bvalid=%b bresp=%b wen=%b required 1 %b 0",
                         i, bvalid, bresp, sys_if_wen, exp_resp);
            end
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_bdone addr=%h: bvalid=%b required 0", a, bvalid);
        end
        checks++;
        if (wen_cnt - n0 !== (exp_err ? 0 : 1)) begin
            errors++;
            $display("FAIL wr_wen_count addr=%h: got %0d required %0d", a, wen_cnt - n0, exp_err ? 0 : 1);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp,
                           input int stall);
        logic hs;
        bit   done;
        done = 1'b0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            hs = arvalid & arready;
            tick();
            if (hs) begin arvalid = 1'b0; done = 1'b1; end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rd_accept addr=%h: not accepted within 20 cycles", a);
            arvalid = 1'b0;
        end
        tick();
        checks++;
        if (sys_if_addr !== {a[31:2], 2'b00} || rvalid !== 1'b0 || sys_if_wen !== 1'b0) begin
            errors++;
            $display("FAIL rd_addr addr=%h: sys_if_addr=%h rvalid=%b wen=%b required %h 0 0",
                     a, sys_if_addr, rvalid, sys_if_wen, {a[31:2], 2'b00});
        end
        tick();
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== exp_resp) begin
            errors++;
            $display("FAIL rd_resp addr=%h: rvalid=%b rdata=%h rresp=%b required 1 %h %b",
                     a, rvalid, rdata, rresp, exp_d, exp_resp);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            checks++;
            if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== exp_resp) begin
                errors++;
                $display("FAIL rd_stall cycle %0d: rvalid=%b rdata=%h rresp=%b required 1 %h %b",
                         i, rvalid, rdata, rresp, exp_d, exp_resp);
            end
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_rdone addr=%h: rvalid=%b required 0", a, rvalid);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, sys_if_wen} !== 6'b0 ||
            bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0 ||
            sys_if_addr !== 32'h0 || sys_if_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b%b%b bv=%b rv=%b wen=%b bresp=%b rresp=%b rdata=%h addr=%h wdata=%h required all 0",
                     awready, wready, arready, bvalid, rvalid, sys_if_wen, bresp, rresp, rdata, sys_if_addr, sys_if_wdata);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_init_ready: readys=%b required 000 before first edge", {awready, wready, arready});
        end
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready_up: readys=%b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_single_write();
        do_write(32'h24, 32'h0000_002A, 4'hF, 1'b0, 0);
    endtask

    task automatic test_single_read();
        do_read(32'h28, 32'h0000_003F, 2'b00, 0);
        do_read(32'h24, 32'h0000_002A, 2'b00, 0);
    endtask

    task automatic test_w_before_aw();
        int n0;
        n0 = wen_cnt;
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_wready: wready=%b required 1", wready);
        end
        tick();
        wvalid = 1'b0;
        tick();
        tick();
        awaddr = 32'h14; awvalid = 1'b1;
        checks++;
        if (sys_if_wen !== 1'b0 || wready !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_wait: wen=%b wready=%b awready=%b required 0 0 1", sys_if_wen, wready, awready);
        end
        tick();
        awvalid = 1'b0;
        tick();
        checks++;
        if (sys_if_wen !== 1'b1 || sys_if_addr !== 32'h14 || sys_if_wdata !== 32'h1) begin
            errors++;
            $display("FAIL wfirst_pulse: wen=%b addr=%h wdata=%h required 1 00000014 00000001",
                     sys_if_wen, sys_if_addr, sys_if_wdata);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL wfirst_resp: bvalid=%b bresp=%b required 1 00", bvalid, bresp);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if (wen_cnt - n0 !== 1) begin
            errors++;
            $display("FAIL wfirst_wen_count: got %0d required 1", wen_cnt - n0);
        end
    endtask

    task automatic test_errors();
        do_write(32'h40, 32'h1234_5678, 4'hF, 1'b1, 0);
        do_write(32'h24, 32'h0000_0BAD, 4'h3, 1'b1, 0);
        do_read(32'h24, 32'h0000_002A, 2'b00, 0);
        do_read(32'h100, 32'h0, 2'b10, 0);
    endtask

    task automatic test_contention();
        int n0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        n0 = wen_cnt;
        awaddr = 32'h30; wdata = 32'h55; wstrb = 4'hF; araddr = 32'h38;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        checks++;
        if (sys_if_wen !== 1'b1 || sys_if_addr !== 32'h30) begin
            errors++;
            $display("FAIL contend1_write_first: wen=%b addr=%h required 1 00000030", sys_if_wen, sys_if_addr);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL contend1_bresp: bvalid=%b rvalid=%b required 1 0", bvalid, rvalid);
        end
        // Second write arrives while the read is still pending: both compete at IDLE.
        awaddr = 32'h34; wdata = 32'h66; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        tick();
        checks++;
        if (sys_if_wen !== 1'b0 || sys_if_addr !== 32'h38) begin
            errors++;
            $display("FAIL contend2_read_first: wen=%b addr=%h required 0 00000038", sys_if_wen, sys_if_addr);
        end
        tick();
        checks++;
        if (rvalid !== 1'b1 || bvalid !== 1'b0 || rdata !== 32'h1000_000E || rresp !== 2'b00) begin
            errors++;
            $display("FAIL contend2_rresp: rvalid=%b bvalid=%b rdata=%h rresp=%b required 1 0 1000000e 00",
                     rvalid, bvalid, rdata, rresp);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        tick();
        checks++;
        if (sys_if_wen !== 1'b1 || sys_if_addr !== 32'h34 || sys_if_wdata !== 32'h66) begin
            errors++;
            $display("FAIL contend2_write_second: wen=%b addr=%h wdata=%h required 1 00000034 00000066",
                     sys_if_wen, sys_if_addr, sys_if_wdata);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL contend2_bresp: bvalid=%b bresp=%b required 1 00", bvalid, bresp);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if (wen_cnt - n0 !== 2) begin
            errors++;
            $display("FAIL contend_wen_count: got %0d required 2", wen_cnt - n0);
        end
    endtask

    task automatic test_back_to_back();
        do_write(32'h3C, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
        do_read(32'h3C, 32'hDEAD_BEEF, 2'b00, 0);
        do_read(32'h30, 32'h0000_0055, 2'b00, 0);
    endtask

    task automatic test_stall();
        do_write(32'h08, 32'hCAFE_0008, 4'hF, 1'b0, 10);
        do_read(32'h08, 32'hCAFE_0008, 2'b00, 10);
    endtask

    task automatic test_reset_midtxn();
        int n0;
        awaddr = 32'h20; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_wr_resp: bvalid=%b required 1", bvalid);
        end
        n0 = wen_cnt;
        rstn = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, sys_if_wen} !== 6'b0 ||
            bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0 ||
            sys_if_addr !== 32'h0 || sys_if_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_outputs: rdy=%b%b%b bv=%b rv=%b wen=%b addr=%h wdata=%h required all 0",
                     awready, wready, arready, bvalid, rvalid, sys_if_wen, sys_if_addr, sys_if_wdata);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        tick();
        checks++;
        if (bvalid !== 1'b0 || wen_cnt !== n0) begin
            errors++;
            $display("FAIL midrst_dropped: bvalid=%b wen_delta=%0d required 0 0", bvalid, wen_cnt - n0);
        end
        do_read(32'h20, 32'h7, 2'b00, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[10] = 32'h0000_003F;
        rstn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_single_write();
        test_single_read();
        test_w_before_aw();
        test_errors();
        test_contention();
        test_back_to_back();
        test_stall();
        test_reset_midtxn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_if_axil_bridge.md
# sys_if_axil_bridge

AXI4-Lite slave that acts as the initiator of the single-cycle `sys_if` register bus. It converts host AXI4-Lite reads and writes into `sys_if_addr`/`sys_if_wen`/`sys_if_wdata` cycles and samples `sys_if_rdata` for read responses. It sits between the host interconnect and one `sys_if` register block, and serialises read and write traffic with round-robin arbitration.

## Interface
- `ADDR_SPAN`, default 'h40: byte span of the attached register block; offsets at or above it return SLVERR.
- `sys_if_clk` in 1: single clock for the AXI and `sys_if` sides.
- `sys_if_rstn` in 1: asynchronous, active-low reset.
- `s_axil_awaddr` in 32, `s_axil_awvalid` in 1, `s_axil_awready` out 1: write address channel.
- `s_axil_wdata` in 32, `s_axil_wstrb` in 4, `s_axil_wvalid` in 1, `s_axil_wready` out 1: write data channel.
- `s_axil_bresp` out 2, `s_axil_bvalid` out 1, `s_axil_bready` in 1: write response channel.
- `s_axil_araddr` in 32, `s_axil_arvalid` in 1, `s_axil_arready` out 1: read address channel.
- `s_axil_rdata` out 32, `s_axil_rresp` out 2, `s_axil_rvalid` out 1, `s_axil_rready` in 1: read data channel.
- `sys_if_wen` out 1: one-cycle write strobe.
- `sys_if_addr` out 32: registered, word-aligned (bits [1:0] forced to 0).
- `sys_if_wdata` out 32: registered write data.
- `sys_if_rdata` in 32: combinational read data for the current `sys_if_addr`.

## Operation
- **Reset values.** All outputs reset to 0: valids, readys, `sys_if_wen`, `sys_if_addr`, `sys_if_wdata`, `bresp`, `rresp`, `rdata`. The FSM resets to IDLE, holding flags clear, `last_wr` = 0.
- **Ready outputs.**
  - An `init` flop sets on the first clock after reset deassertion. All three readys stay 0 until it is set.
  - `awready` = `init` & !`aw_held`. `wready` = `init` & !`w_held`. `arready` = `init` & !`ar_held`.
- **Holding registers.**
  - An AW, W or AR handshake captures its payload into a holding register and sets the corresponding `*_held` flag.
  - AW and W are accepted independently and in either order.
- **FSM states:** IDLE, WR_PULSE, WR_RESP, RD_ADDR, RD_RESP.
- **Transitions out of IDLE:**
  - A write is pending when `aw_held` & `w_held`. A read is pending when `ar_held`.
  - Only one pending: go to WR_PULSE or RD_ADDR respectively.
  - Both pending: grant write if `last_wr` = 0, otherwise grant read. `last_wr` updates on every grant.
  - At the IDLE exit edge, load `sys_if_addr` = {addr[31:2], 2'b00} and `sys_if_wdata` (writes only).
- **WR_PULSE** (one cycle):
  - The access is in error when offset ≥ `ADDR_SPAN` or `wstrb` != 4'hF.
  - `sys_if_wen` = 1 only if there is no error.
  - Clear `aw_held` and `w_held`, go to WR_RESP.
- **WR_RESP:**
  - `bvalid` = 1; `bresp` = 2'b10 on error, 2'b00 otherwise.
  - On `bready`, go to IDLE.
- **RD_ADDR** (one cycle):
  - At the exit edge, register `rdata` = `sys_if_rdata`, or 0 if offset ≥ `ADDR_SPAN`.
  - Clear `ar_held`, go to RD_RESP.
- **RD_RESP:**
  - `rvalid` = 1; `rresp` = SLVERR on out-of-span, OKAY otherwise.
  - On `rready`, go to IDLE.
- **Idle bus.** `sys_if_addr` and `sys_if_wdata` hold their last values between transactions. `sys_if_wen` is never asserted outside WR_PULSE.
- **Reset mid-transaction.** The transaction is dropped; there is no response and no `sys_if_wen`. AXI-side recovery is the host's responsibility.

## Timing
- **Write latency.** Last of the AW/W handshakes at edge k:
  - `sys_if_wen` is high for exactly cycle k+1 → k+2.
  - The register block updates at edge k+2.
  - `bvalid` rises at edge k+2.
- **Read latency.** AR handshake at edge k:
  - `sys_if_addr` is valid from edge k+1.
  - `rdata` is sampled and `rvalid` rises at edge k+2.
- **Back-to-back.** A new transaction can be granted on the clock edge after the B or R handshake completes, so the minimum period is 3 cycles per access.
- **Read-after-write.** A read granted after its preceding write's B handshake always observes the written value.
- **Acceptance while busy.** Holding registers may accept new AW/W/AR while the FSM is busy. At most one of each is buffered; ready stays low while that channel's holding register is full.
- **Stability.** `bvalid`/`rvalid` and their payloads stay stable until the handshake completes.

## Structure
- **Shared package `sys_if_pkg`:**
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Bridge state enum.
  - SYS_IF_AW = 32, SYS_IF_DW = 32.
- **Sub-module `axil_chan_hold`:**
  - Parameterised payload width; valid/ready capture, held flag, clear input.
  - Instantiated three times: AW, W, AR.
- **Top level:** FSM, arbiter, `sys_if` output registers, response registers.

## Test plan
- **Single write.** AW 0x24 and W 0x0000002A (`wstrb` F) in the same cycle → `sys_if_wen` pulses 1 cycle with addr 0x24, wdata 0x2A; `bresp` 00; `bvalid` 2 cycles after the handshake.
- **Single read.** AR 0x28 while the bench drives `sys_if_rdata` = 0x3F at that address → `rdata` 0x3F, `rresp` 00, `rvalid` 2 cycles after the AR handshake.
- **W before AW.** W 0x1 three cycles before AW 0x14 → exactly one `sys_if_wen`, at addr 0x14, 1 cycle after the AW handshake.
- **Error cases.**
  - AW 0x40 → `bresp` 10 and no `sys_if_wen`.
  - AW 0x24 with `wstrb` 4'h3 → `bresp` 10 and no `sys_if_wen`.
  - AR 0x100 → `rresp` 10, `rdata` 0.
- **Contention.**
  - Write and read pending together just after reset → write serviced first.
  - Second simultaneous pair → read serviced first.
- **Stalls and reset.**
  - Hold `bready`/`rready` low for 10 cycles → response stays stable, no new `sys_if_wen`.
  - Reset asserted during WR_RESP → all outputs 0 immediately, IDLE after release.
